// File: rtl/vga_pixel_scanner.sv
// vga_pixel_scanner
//   Raster scan master for the billiard display pipeline. Walks pixelX/pixelY
//   over the full VGA frame (active area, porches and sync), collects the
//   registered drawingRequest/RGB_in answer one clock later and emits
//   hsync/vsync/blank/RGB_out aligned with a fixed 2-clock latency.
//
//   Ports
//     clk            in   pixel clock
//     resetN         in   synchronous reset, active high
//     drawingRequest in   merged object request, valid 1 clk after pixelX/pixelY
//     RGB_in         in   merged object colour, same timing as drawingRequest
//     pixelX         out  horizontal count 0..H_TOTAL-1
//     pixelY         out  vertical count 0..V_TOTAL-1
//     startOfFrame   out  high while pixelX=0 and pixelY=0 (stage-0 aligned)
//     hsync          out  active-low horizontal sync (stage-2 aligned)
//     vsync          out  active-low vertical sync (stage-2 aligned)
//     blank          out  high outside the active area (stage-2 aligned)
//     RGB_out        out  final pixel colour
//
//   Build option: define VGA_BORDER_EN to force a white (8'hFF) one-pixel
//   border around the active area.
module vga_pixel_scanner #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic [7:0]  BG_RGB   = 8'h00
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        drawingRequest,
  input  logic [7:0]  RGB_in,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        startOfFrame,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic [7:0]  RGB_out
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT     = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT     = 11'(V_ACTIVE);
  localparam logic [10:0] H_SYNC_LO = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_HI = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_SYNC_LO = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_HI = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] r_h;
  logic [10:0] r_v;

  // stage 0: raw timing decoded from the counters
  logic w_hsync0;
  logic w_vsync0;
  logic w_blank0;

  // stage 1: delayed timing, meets the object answer
  logic r_hsync1;
  logic r_vsync1;
  logic r_blank1;
  logic [7:0] w_colour1;

  // stage 2: output registers
  logic r_hsync2;
  logic r_vsync2;
  logic r_blank2;
  logic [7:0] r_rgb2;

  always_ff @(posedge clk) begin
    if (resetN) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == H_LAST) begin
      r_h <= '0;
      r_v <= (r_v == V_LAST) ? '0 : r_v + 11'd1;
    end else begin
      r_h <= r_h + 11'd1;
    end
  end

  always_comb begin
    w_hsync0 = ~((r_h >= H_SYNC_LO) && (r_h < H_SYNC_HI));
    w_vsync0 = ~((r_v >= V_SYNC_LO) && (r_v < V_SYNC_HI));
    w_blank0 = (r_h >= H_ACT) || (r_v >= V_ACT);
  end

`ifdef VGA_BORDER_EN
  logic w_border0;
  logic r_border1;

  // Border is decided on the stage-0 coordinates and delayed one clock so
  // it lines up with the object answer at the colour mux.
  always_comb begin
    w_border0 = (r_h == '0) || (r_h == H_ACT - 11'd1) ||
                (r_v == '0) || (r_v == V_ACT - 11'd1);
  end

  always_ff @(posedge clk) begin
    if (resetN) r_border1 <= 1'b0;
    else        r_border1 <= w_border0;
  end

  always_comb begin
    w_colour1 = '0;
    if (!r_blank1) begin
      if (r_border1)           w_colour1 = 8'hFF;
      else if (drawingRequest) w_colour1 = RGB_in;
      else                     w_colour1 = BG_RGB;
    end
  end
`else
  always_comb begin
    w_colour1 = '0;
    if (!r_blank1) begin
      if (drawingRequest) w_colour1 = RGB_in;
      else                w_colour1 = BG_RGB;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (resetN) begin
      r_hsync1 <= 1'b1;
      r_vsync1 <= 1'b1;
      r_blank1 <= 1'b1;
      r_hsync2 <= 1'b1;
      r_vsync2 <= 1'b1;
      r_blank2 <= 1'b1;
      r_rgb2   <= '0;
    end else begin
      r_hsync1 <= w_hsync0;
      r_vsync1 <= w_vsync0;
      r_blank1 <= w_blank0;
      r_hsync2 <= r_hsync1;
      r_vsync2 <= r_vsync1;
      r_blank2 <= r_blank1;
      r_rgb2   <= w_colour1;
    end
  end

  always_comb begin
    pixelX       = r_h;
    pixelY       = r_v;
    startOfFrame = (r_h == '0) && (r_v == '0);
    hsync        = r_hsync2;
    vsync        = r_vsync2;
    blank        = r_blank2;
    RGB_out      = r_rgb2;
  end

endmodule

// File: doc/vga_pixel_scanner.md
# vga_pixel_scanner

Raster scan master for the billiard display pipeline. Generates the pixelX/pixelY coordinates that every drawing object (ball, hole, table, cue) compares against, collects the registered drawingRequest/RGB answer returned one clock later, and emits time-aligned VGA hsync, vsync, blank and RGB. It is the initiator end of the object pixel-query interface; objects are pure responders.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- BG_RGB, 8'h00, background colour when no object requests the pixel

- clk  in  1  pixel clock (25.175 MHz nominal)
- resetN  in  1  synchronous, active-high reset (asserted when 1)
- drawingRequest  in  1  merged object request, registered by objects, valid 1 clk after the pixelX/pixelY it answers
- RGB_in  in  8  merged object colour, same timing as drawingRequest
- pixelX  out  11  current horizontal count, 0..H_TOTAL-1
- pixelY  out  11  current vertical count, 0..V_TOTAL-1
- startOfFrame  out  1  one-clock pulse when pixelX=0 and pixelY=0
- hsync  out  1  active-low horizontal sync, aligned to RGB_out
- vsync  out  1  active-low vertical sync, aligned to RGB_out
- blank  out  1  1 outside the active area, aligned to RGB_out
- RGB_out  out  8  final pixel colour

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525). Counters 11 bits.
- Horizontal counter increments every clk; at H_TOTAL-1 wraps to 0 and vertical counter increments; vertical wraps to 0 at V_TOTAL-1 coinciding with horizontal wrap.
- pixelX/pixelY are the counter registers themselves; they walk porches and sync too, so objects may assert drawingRequest off-screen — masked here.
- Stage 0 (cycle n): pixelX/pixelY presented. Stage 1 (n+1): drawingRequest/RGB_in valid; scanner computes colour = blank_d1 ? 0 : (drawingRequest ? RGB_in : BG_RGB). Stage 2 (n+2): colour registered onto RGB_out.
- Raw hsync_0 = 0 when H_ACTIVE+H_FP <= pixelX < H_ACTIVE+H_FP+H_SYNC; vsync_0 analogous on pixelY; blank_0 = (pixelX >= H_ACTIVE) || (pixelY >= V_ACTIVE). Each passes through a 2-deep register chain to align with RGB_out.
- startOfFrame is combinational on the counters (stage-0 aligned) so game logic can latch ball positions before the first visible pixel.
- Reset: counters 0, hsync=1, vsync=1, blank=1, RGB_out=0, all delay stages cleared to those idle values. Reset mid-frame restarts at (0,0) the clock after release; no partial-line recovery.
- Inputs drawingRequest/RGB_in are ignored whenever the aligned blank is 1.

## Timing
- pixel-to-RGB_out latency: exactly 2 clk. hsync/vsync/blank share this latency, so the first visible RGB_out appears 2 clk after pixelX=0,pixelY=0.
- First clock after reset release: pixelX=0, pixelY=0, startOfFrame=1.
- hsync low for exactly H_SYNC clk per line; vsync low for exactly V_SYNC×H_TOTAL clk per frame, edges coincident with hsync line boundary (both delayed by 2).
- Frame period: H_TOTAL×V_TOTAL = 420000 clk.

## Configuration
- VGA_BORDER_EN defined: any active pixel with pixelX ∈ {0, H_ACTIVE-1} or pixelY ∈ {0, V_ACTIVE-1} outputs 8'hFF regardless of drawingRequest (border decision computed at stage 0, delayed 1 clk to meet the mux). Not defined: no border logic; colour rule as in Operation.

## Test plan
- Reset held 5 clk then released -> pixelX=0, pixelY=0, startOfFrame=1 on first clk; hsync=vsync=1, blank=1, RGB_out=0 during reset.
- Free run one line -> pixelX 0..799 then 0, pixelY increments once; hsync low exactly at delayed counts 656..751 (96 clk), blank high for 160 clk.
- Free run one frame -> startOfFrame pulses once per 420000 clk; vsync low for 1600 clk starting when pixelY=490 appears at output (2 clk delay).
- Responder model returns drawingRequest=1, RGB_in=8'h1C one clk after pixelX=100,pixelY=50 -> RGB_out=8'h1C exactly 2 clk after that coordinate; neighbouring pixels show BG_RGB.
- drawingRequest=1 held constant, RGB_in=8'hE0 -> RGB_out=0 whenever aligned blank=1 (e.g. pixelX=700); 8'hE0 in active area; with VGA_BORDER_EN, pixelX=0/639 and pixelY=0/479 show 8'hFF.
- Assert resetN at pixelX=300,pixelY=200 for 1 clk -> next clk counters at (0,0), outputs idle values for 2 clk, then normal scan resumes.
